// File: rtl/ext_sram_ctrl_pkg.sv
// Shared definitions for the external asynchronous-SRAM controller.
package ext_sram_ctrl_pkg;

    localparam int LAT_W = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/ext_sram_ctrl_byte_merge.sv
// Per-lane merge of new write data over the word read back from SRAM.
module ext_sram_ctrl_byte_merge #(
    parameter int BYTES = 4
) (
    input  logic [BYTES-1:0]   be,
    input  logic [8*BYTES-1:0] wdata,
    input  logic [8*BYTES-1:0] rdata,
    output logic [8*BYTES-1:0] merged
);

    always_comb begin
        // NOTE: full default before the loop keeps every lane assigned on every path, so no latch.
        merged = rdata;
        for (int i = 0; i < BYTES; i++) begin
            if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

endmodule

// File: rtl/ext_sram_ctrl.sv
// Asynchronous-SRAM controller: CPU request port to SRAM strobes, with native
// byte lanes or read-modify-write for partial writes.
module ext_sram_ctrl
    import ext_sram_ctrl_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 19,
    parameter int RD_LAT       = 1,
    parameter int WR_LAT       = 1,
    parameter int RMW_RD_LAT   = 1,
    parameter int RMW_WR_LAT   = 1,
    parameter bit NATIVE_BE    = 1'b0,
    parameter bit EARLY_WR_ACK = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_rd,
    input  logic                 req_wr,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W/8-1:0]  req_be,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 rdy,
    output logic [DATA_W-1:0]    rdata,
    output logic                 busy,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic                 ram_cs_b,
    output logic                 ram_oe_b,
    output logic                 ram_we_b,
    output logic [DATA_W/8-1:0]  ram_be_b,
    input  logic [DATA_W-1:0]    ram_dq_in,
    output logic [DATA_W-1:0]    ram_dq_out,
    output logic                 ram_dq_oe
);

    localparam int BYTES = DATA_W / 8;
    localparam logic [LAT_W-1:0] RD_L  = LAT_W'(RD_LAT);
    localparam logic [LAT_W-1:0] WR_L  = LAT_W'(WR_LAT);
    localparam logic [LAT_W-1:0] RRD_L = LAT_W'(RMW_RD_LAT);
    localparam logic [LAT_W-1:0] RWR_L = LAT_W'(RMW_WR_LAT);
    localparam logic [LAT_W-1:0] ONE   = LAT_W'(1);

    state_t            state;
    logic [LAT_W-1:0]  lcount;
    logic [BYTES-1:0]  be_q;
    logic              ack_sent;
    logic [DATA_W-1:0] merged;

    ext_sram_ctrl_byte_merge #(.BYTES(BYTES)) u_merge (
        .be     (be_q),
        .wdata  (ram_dq_out),
        .rdata  (ram_dq_in),
        .merged (merged)
    );

    // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lcount     <= '0;
            be_q       <= '0;
            ack_sent   <= 1'b0;
            rdy        <= 1'b0;
            busy       <= 1'b0;
            rdata      <= '0;
            ram_addr   <= '0;
            ram_cs_b   <= 1'b1;
            ram_oe_b   <= 1'b1;
            ram_we_b   <= 1'b1;
            ram_be_b   <= '1;
            ram_dq_out <= '0;
            ram_dq_oe  <= 1'b0;
        end else begin
            rdy <= 1'b0;
            unique case (state)
                IDLE: begin
                    ack_sent <= 1'b0;
                    if (req_rd) begin
                        state    <= READ;
                        busy     <= 1'b1;
                        ram_addr <= req_addr;
                        ram_cs_b <= 1'b0;
                        ram_oe_b <= 1'b0;
                        ram_be_b <= '0;
                        lcount   <= RD_L;
                    end else if (req_wr) begin
                        busy       <= 1'b1;
                        ram_addr   <= req_addr;
                        be_q       <= req_be;
                        ram_dq_out <= req_wdata;
                        if (req_be == '0) begin
                            // Nothing to write: acknowledge without touching the SRAM.
                            state <= DONE;
                            rdy   <= 1'b1;
                        end else if ((&req_be) || NATIVE_BE) begin
                            state     <= WRITE;
                            ram_cs_b  <= 1'b0;
                            ram_we_b  <= 1'b0;
                            ram_be_b  <= NATIVE_BE ? ~req_be : '0;
                            ram_dq_oe <= 1'b1;
                            lcount    <= WR_L;
                        end else begin
                            state    <= RMW_RD;
                            ram_cs_b <= 1'b0;
                            ram_oe_b <= 1'b0;
                            ram_be_b <= '0;
                            lcount   <= RRD_L;
                        end
                    end
                end

                READ: begin
                    if (lcount != '0) begin
                        lcount <= lcount - ONE;
                    end else begin
                        rdata    <= ram_dq_in;
                        ram_cs_b <= 1'b1;
                        ram_oe_b <= 1'b1;
                        ram_be_b <= '1;
                        rdy      <= 1'b1;
                        state    <= DONE;
                    end
                end

                RMW_RD: begin
                    if (lcount != '0) begin
                        lcount <= lcount - ONE;
                    end else begin
                        // Output enable drops in the same edge the pad starts driving.
                        ram_dq_out <= merged;
                        ram_oe_b   <= 1'b1;
                        ram_we_b   <= 1'b0;
                        ram_dq_oe  <= 1'b1;
                        lcount     <= RWR_L;
                        state      <= WRITE;
                    end
                end

                WRITE: begin
                    if (lcount != '0) begin
                        lcount <= lcount - ONE;
                        if (EARLY_WR_ACK && lcount == ONE) begin
                            rdy      <= 1'b1;
                            ack_sent <= 1'b1;
                        end
                    end else begin
                        ram_cs_b  <= 1'b1;
                        ram_we_b  <= 1'b1;
                        ram_be_b  <= '1;
                        ram_dq_oe <= 1'b0;
                        rdy       <= !ack_sent;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy      <= 1'b0;
                    ram_cs_b  <= 1'b1;
                    ram_oe_b  <= 1'b1;
                    ram_we_b  <= 1'b1;
                    ram_be_b  <= '1;
                    ram_dq_oe <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_sram_ctrl.sv
// Bench for ext_sram_ctrl: two configurations against a word-level memory model.
module tb_ext_sram_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  req_rd = '0;
    logic [1:0]  req_wr = '0;
    logic [7:0]  req_addr = '0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;

    logic [1:0]  rdy, busy, cs_b, oe_b, we_b, dq_oe;
    logic [31:0] rdata [2];
    logic [31:0] dq_out [2];
    logic [31:0] dq_in [2];
    logic [7:0]  addr_o [2];
    logic [3:0]  be_b [2];

    // Instance 0: RMW partial writes, late ack. Instance 1: native lanes, early ack, longer latencies.
    ext_sram_ctrl #(.DATA_W(32), .ADDR_W(8), .RD_LAT(1), .WR_LAT(1), .RMW_RD_LAT(1),
                    .RMW_WR_LAT(1), .NATIVE_BE(1'b0), .EARLY_WR_ACK(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req_rd(req_rd[0]), .req_wr(req_wr[0]), .req_addr(req_addr),
        .req_be(req_be), .req_wdata(req_wdata), .rdy(rdy[0]), .rdata(rdata[0]), .busy(busy[0]),
        .ram_addr(addr_o[0]), .ram_cs_b(cs_b[0]), .ram_oe_b(oe_b[0]), .ram_we_b(we_b[0]),
        .ram_be_b(be_b[0]), .ram_dq_in(dq_in[0]), .ram_dq_out(dq_out[0]), .ram_dq_oe(dq_oe[0]));

    ext_sram_ctrl #(.DATA_W(32), .ADDR_W(8), .RD_LAT(2), .WR_LAT(3), .RMW_RD_LAT(1),
                    .RMW_WR_LAT(1), .NATIVE_BE(1'b1), .EARLY_WR_ACK(1'b1)) dut1 (
        .clk(clk), .rst(rst), .req_rd(req_rd[1]), .req_wr(req_wr[1]), .req_addr(req_addr),
        .req_be(req_be), .req_wdata(req_wdata), .rdy(rdy[1]), .rdata(rdata[1]), .busy(busy[1]),
        .ram_addr(addr_o[1]), .ram_cs_b(cs_b[1]), .ram_oe_b(oe_b[1]), .ram_we_b(we_b[1]),
        .ram_be_b(be_b[1]), .ram_dq_in(dq_in[1]), .ram_dq_out(dq_out[1]), .ram_dq_oe(dq_oe[1]));

    // Board SRAM models: lane-masked write while cs/we low, read data only while cs/oe low.
    logic [31:0] mem [0:1][0:255];
    logic [31:0] ref_mem [0:1][0:255];

    for (genvar g = 0; g < 2; g++) begin : g_sram
        assign dq_in[g] = (!cs_b[g] && !oe_b[g]) ? mem[g][addr_o[g]] : 32'hxxxx_xxxx;
        always @(posedge clk) begin : wr_port
            logic [31:0] w;
            if (!cs_b[g] && !we_b[g]) begin
                w = mem[g][addr_o[g]];
                for (int i = 0; i < 4; i++)
                    if (!be_b[g][i]) w[8*i +: 8] = dq_out[g][8*i +: 8];
                mem[g][addr_o[g]] <= w;
            end
        end
    end

    int checks = 0;
    int failures = 0;
    int ov_cnt, oe_cnt, cs_cnt, addr_err, dbl_rdy, stuck;
    logic [3:0] wr_be_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected edges from acceptance edge E0 to the edge that registers rdy.
    function automatic int exp_lat(input int sel, input bit rd, input logic [3:0] be);
        int rd_l, wr_l, rr_l, rw_l;
        bit nat, early;
        rd_l = (sel == 0) ? 1 : 2;  wr_l = (sel == 0) ? 1 : 3;
        rr_l = 1;                   rw_l = 1;
        nat  = (sel == 1);          early = (sel == 1);
        if (rd) return rd_l + 1;
        if (be == 4'h0) return 0;
        if (be == 4'hF || nat) return (early && wr_l >= 1) ? wr_l : wr_l + 1;
        return rr_l + 1 + ((early && rw_l >= 1) ? rw_l : rw_l + 1);
    endfunction

    function automatic logic [9:0] strobes(input int sel);
        return {cs_b[sel], oe_b[sel], we_b[sel], be_b[sel], dq_oe[sel], rdy[sel], busy[sel]};
    endfunction

    localparam logic [9:0] RESET_STROBES = 10'b111_1111_000;

    task automatic sample(input int sel, input logic [7:0] a);
        if (!oe_b[sel] && dq_oe[sel]) ov_cnt++;
        if (!oe_b[sel] && !we_b[sel]) ov_cnt++;
        if (!oe_b[sel]) oe_cnt++;
        if (!cs_b[sel]) begin
            cs_cnt++;
            if (addr_o[sel] !== a) addr_err++;
        end
        if (!we_b[sel]) wr_be_b = be_b[sel];
    endtask

    task automatic access(input int sel, input bit rd, input bit wr, input logic [7:0] a,
                          input logic [3:0] be, input logic [31:0] wd,
                          output int lat, output logic [31:0] data);
        ov_cnt = 0; oe_cnt = 0; cs_cnt = 0; addr_err = 0; dbl_rdy = 0; stuck = 0;
        wr_be_b = 4'hF; lat = -1; data = '0;
        @(negedge clk);
        req_rd[sel] = rd; req_wr[sel] = wr; req_addr = a; req_be = be; req_wdata = wd;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            sample(sel, a);
            if (rdy[sel]) begin
                lat = k; data = rdata[sel];
                break;
            end
        end
        @(negedge clk);
        req_rd[sel] = 1'b0; req_wr[sel] = 1'b0;
        for (int k = 0; k < 10 && busy[sel]; k++) begin
            @(posedge clk); #1;
            sample(sel, a);
            if (rdy[sel]) dbl_rdy++;
        end
        if (busy[sel]) stuck = 1;
    endtask

    task automatic run_op(input int sel, input bit rd, input bit wr, input logic [7:0] a,
                          input logic [3:0] be, input logic [31:0] wd, input string tag);
        int lat;
        logic [31:0] data;
        access(sel, rd, wr, a, be, wd, lat, data);
        check({tag, "_lat"}, lat, exp_lat(sel, rd, be));
        if (rd) check({tag, "_rdata"}, data, ref_mem[sel][a]);
        else if (wr)
            for (int i = 0; i < 4; i++)
                if (be[i]) ref_mem[sel][a][8*i +: 8] = wd[8*i +: 8];
        check({tag, "_protocol"}, ov_cnt + addr_err + dbl_rdy + stuck, 0);
    endtask

    initial begin
        int lat, acc;
        logic [31:0] data;

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++) begin
                mem[s][i] = '0;
                ref_mem[s][i] = '0;
            end

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset_strobes%0d", s), strobes(s), RESET_STROBES);
            check($sformatf("reset_rdata%0d", s), rdata[s], 32'h0);
            check($sformatf("reset_addr%0d", s), addr_o[s], 8'h0);
        end
        @(negedge clk) rst = 1'b0;

        // Full write then read back on the RMW configuration.
        run_op(0, 0, 1, 8'h10, 4'hF, 32'hDEADBEEF, "t1_wr");
        run_op(0, 1, 0, 8'h10, 4'hF, 32'h0, "t1_rd");

        // Partial write by read-modify-write.
        run_op(0, 0, 1, 8'h20, 4'hF, 32'h11223344, "t2_init");
        run_op(0, 0, 1, 8'h20, 4'h2, 32'hAABBCCDD, "t2_rmw");
        check("t2_rmw_read_phase", oe_cnt, 2);
        run_op(0, 1, 0, 8'h20, 4'h0, 32'h0, "t2_rd");
        check("t2_rd_value", ref_mem[0][8'h20], 32'h1122CC44);

        // Native byte lanes: single write phase, no output-enable pulse.
        run_op(1, 0, 1, 8'h20, 4'hF, 32'h11223344, "t3_init");
        run_op(1, 0, 1, 8'h20, 4'h2, 32'hAABBCCDD, "t3_native");
        check("t3_no_oe", oe_cnt, 0);
        check("t3_be_b", wr_be_b, 4'hD);
        run_op(1, 1, 0, 8'h20, 4'h0, 32'h0, "t3_rd");

        // Early ack, then a read held immediately behind it.
        @(negedge clk);
        req_wr[1] = 1'b1; req_addr = 8'h40; req_be = 4'hF; req_wdata = 32'hCAFEF00D;
        lat = -1; acc = -1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (rdy[1] && lat < 0) lat = k;
            if (!oe_b[1]) begin
                acc = k;
                break;
            end
            @(negedge clk);
            if (lat >= 0 && req_wr[1]) begin
                req_wr[1] = 1'b0; req_rd[1] = 1'b1;
            end
        end
        ref_mem[1][8'h40] = 32'hCAFEF00D;
        check("t4_early_lat", lat, 3);
        check("t4_read_accept", acc, 6);
        data = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (rdy[1]) begin
                data = rdata[1];
                break;
            end
        end
        @(negedge clk) req_rd[1] = 1'b0;
        repeat (2) @(posedge clk);
        check("t4_rdata", data, 32'hCAFEF00D);

        // Zero byte-enable write and simultaneous read/write.
        run_op(0, 0, 1, 8'h10, 4'h0, 32'h12345678, "t5_be0");
        check("t5_be0_no_cs", cs_cnt, 0);
        run_op(0, 1, 1, 8'h10, 4'hF, 32'h55555555, "t5_rdwr");
        run_op(0, 1, 0, 8'h10, 4'hF, 32'h0, "t5_after");

        // Randomized mix on both configurations.
        for (int n = 0; n < 60; n++) begin
            int sel, op;
            logic [3:0] be;
            sel = n % 2;
            op = $urandom_range(0, 4);
            be = 4'($urandom_range(0, 15));
            run_op(sel, op == 0 || op == 4, op != 0, 8'h30 + 8'($urandom_range(0, 7)),
                   be, $urandom, $sformatf("rand%0d", n));
        end
        for (int s = 0; s < 2; s++)
            for (int a = 8'h30; a < 8'h38; a++)
                check($sformatf("mem%0d_%0h", s, a), mem[s][a], ref_mem[s][a]);

        // Reset during a read.
        @(negedge clk);
        req_rd[0] = 1'b1; req_addr = 8'h10;
        @(posedge clk); #1;
        check("t6_read_started", oe_b[0], 1'b0);
        @(negedge clk);
        rst = 1'b1; req_rd[0] = 1'b0;
        @(posedge clk); #1;
        check("t6_rd_reset_strobes", strobes(0), RESET_STROBES);
        check("t6_rd_reset_rdata", rdata[0], 32'h0);
        @(negedge clk) rst = 1'b0;
        dbl_rdy = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (rdy[0] || busy[0]) dbl_rdy++;
        end
        check("t6_rd_quiet", dbl_rdy, 0);

        // Reset during the write phase of a read-modify-write.
        @(negedge clk);
        req_wr[0] = 1'b1; req_addr = 8'h50; req_be = 4'h4; req_wdata = 32'h99999999;
        acc = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (!we_b[0]) begin
                acc = k;
                break;
            end
        end
        check("t6_rmw_write_phase", acc, 2);
        @(negedge clk);
        rst = 1'b1; req_wr[0] = 1'b0;
        @(posedge clk); #1;
        check("t6_rmw_reset_strobes", strobes(0), RESET_STROBES);
        @(negedge clk) rst = 1'b0;
        dbl_rdy = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (rdy[0] || busy[0]) dbl_rdy++;
        end
        check("t6_rmw_quiet", dbl_rdy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
